// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: CTR-mode sequencer wrapped around a fixed-latency, no-stall AES-256
// encrypt pipeline. It drives counter blocks into the pipeline, delays the plaintext
// alongside them, XORs the returned keystream and buffers the ciphertext. A credit
// check turns the free-running pipeline into valid/ready streams and keeps the FIFO
// from overflowing.
// Build option: define AES_CTR_INC128_EN to make the counter increment carry across
// all 128 bits. When it is undefined, only the low 32 bits increment.
module aes_ctr_sequencer #(
  parameter int unsigned LATENCY   = 14,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] iv,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  input  logic         pt_last,
  output logic [127:0] enc_in,
  input  logic [127:0] enc_out,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data,
  output logic         ct_last,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned IF_W  = $clog2(LATENCY + 1);
  localparam int unsigned SUM_W = $clog2(LATENCY + OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [127:0]         ctr_q, ctr_d;
  logic [LATENCY-1:0]   dl_valid_q, dl_valid_d;
  logic [LATENCY-1:0]   dl_last_q, dl_last_d;
  logic [127:0]         dl_data_q [LATENCY];
  logic [127:0]         dl_data_d [LATENCY];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [127:0]         fifo_data_q [OUT_DEPTH];
  logic                 fifo_last_q [OUT_DEPTH];

  logic [127:0]         ctr_inc_c;
  logic [IF_W-1:0]      in_flight_c;
  logic [SUM_W-1:0]     credit_c;
  logic                 accept_c;
  logic                 push_c;
  logic                 pop_c;
  logic [127:0]         ct_c;

  // Counter increment: the default wraps only the low word, and the option carries through all 128 bits.
  always_comb begin
`ifdef AES_CTR_INC128_EN
    ctr_inc_c = ctr_q + 128'd1;
`else
    ctr_inc_c = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
`endif
  end

  // Credits in use: blocks still inside the pipeline plus blocks waiting in the FIFO.
  always_comb begin
    in_flight_c = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      in_flight_c = in_flight_c + IF_W'(dl_valid_q[i]);
    end
    credit_c = SUM_W'(in_flight_c) + SUM_W'(count_q);
  end

  // FSM next state, counter update and handshake outputs.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    pt_ready = 1'b0;
    done     = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctr_d   = iv;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pt_ready = (credit_c < SUM_W'(OUT_DEPTH));
        accept_c = pt_valid && pt_ready;
        if (accept_c) begin
          ctr_d = ctr_inc_c;
          if (pt_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((in_flight_c == '0) && (count_q == '0)) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Plaintext delay line, matched to the pipeline latency. Bubbles carry valid=0.
  always_comb begin
    dl_valid_d   = {dl_valid_q[LATENCY-2:0], accept_c};
    dl_last_d    = {dl_last_q[LATENCY-2:0], pt_last};
    dl_data_d[0] = pt_data;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dl_data_d[i] = dl_data_q[i-1];
    end
  end

  // Tap of the delay line and FIFO pointer and count updates.
  always_comb begin
    push_c   = dl_valid_q[LATENCY-1];
    ct_c     = enc_out ^ dl_data_q[LATENCY-1];
    pop_c    = (count_q != '0) && ct_ready;
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers. Reset clears all control and discards any blocks in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dl_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      dl_valid_q <= dl_valid_d;
      dl_last_q  <= dl_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dl_data_q[i] <= dl_data_d[i];
      end
    end
  end

  // FIFO storage. Reads are gated by ct_valid, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q] <= ct_c;
      fifo_last_q[wr_ptr_q] <= dl_last_q[LATENCY-1];
    end
  end

  // The credit check should make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst)
                   !(push_c && (count_q == CNT_W'(OUT_DEPTH))));

  assign enc_in   = ctr_q;
  assign ct_valid = (count_q != '0);
  assign ct_data  = ct_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign ct_last  = ct_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  assign busy     = (state_q != ST_IDLE);

endmodule
